// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Default 640x480 timing constants shared by the VGA timing block.
// Revision : 1.0
// ============================================================================
package vga_pkg;

  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;

  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 33;
  localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Brief    : VGA pixel/line counters with a single registered colour+sync stage.
//            Optional vblank interrupt output enabled by macro VGA_VBLANK_IRQ_EN.
// Revision : 1.0
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  input  logic [11:0] pixel,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
`ifdef VGA_VBLANK_IRQ_EN
  ,
  output logic        vblank_irq
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             tick, h_wrap, v_wrap, active, hs_on, vs_on;

  always_comb begin
    tick   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    h_wrap = (h_cnt_q == 10'(H_TOTAL - 1));
    v_wrap = (v_cnt_q == 10'(V_TOTAL - 1));
    active = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
    hs_on  = (h_cnt_q >= 10'(HS_START)) && (h_cnt_q < 10'(HS_END));
    vs_on  = (v_cnt_q >= 10'(VS_START)) && (v_cnt_q < 10'(VS_END));

    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    rgb_d     = rgb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;

    // Output stage decodes the pixel being left, so it lags the counters by one pixel.
    if (tick) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
      end
      rgb_d = active ? pixel : '0;
      hs_d  = hs_on ? SYNC_POL : ~SYNC_POL;
      vs_d  = vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      rgb_q     <= '0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign pixel_x = h_cnt_q;
  assign pixel_y = v_cnt_q;
  assign vga_r   = rgb_q[11:8];
  assign vga_g   = rgb_q[7:4];
  assign vga_b   = rgb_q[3:0];
  assign vga_hs  = hs_q;
  assign vga_vs  = vs_q;

`ifdef VGA_VBLANK_IRQ_EN
  logic irq_q;

  // Fires once as the last active line finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= tick && h_wrap && (v_cnt_q == 10'(V_ACTIVE - 1));
    end
  end

  assign vblank_irq = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Brief    : Self-checking bench: default-timing DUT plus a reduced-timing DUT
//            for whole-frame behaviour. Honours VGA_VBLANK_IRQ_EN.
// Revision : 1.0
// ============================================================================
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT A: default timing ----------------
  logic        rst_a = 1'b1;
  logic [9:0]  px_a, py_a;
  logic [11:0] pix_a = '0, m1_a = '0;
  logic [3:0]  r_a, g_a, b_a;
  logic        hs_a, vs_a, irq_a;

  vga_timing dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .pixel_x    (px_a),
    .pixel_y    (py_a),
    .pixel      (pix_a),
    .vga_r      (r_a),
    .vga_g      (g_a),
    .vga_b      (b_a),
    .vga_hs     (hs_a),
    .vga_vs     (vs_a)
`ifdef VGA_VBLANK_IRQ_EN
    ,
    .vblank_irq (irq_a)
`endif
  );

  // ---------------- DUT B: reduced timing 24x14, CLK_DIV 3 ----------------
  logic        rst_b = 1'b1;
  logic [9:0]  px_b, py_b;
  logic [11:0] pix_b = '0, m1_b = '0;
  logic [3:0]  r_b, g_b, b_b;
  logic        hs_b, vs_b, irq_b;

  vga_timing #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .pixel_x    (px_b),
    .pixel_y    (py_b),
    .pixel      (pix_b),
    .vga_r      (r_b),
    .vga_g      (g_b),
    .vga_b      (b_b),
    .vga_hs     (hs_b),
    .vga_vs     (vs_b)
`ifdef VGA_VBLANK_IRQ_EN
    ,
    .vblank_irq (irq_b)
`endif
  );

`ifndef VGA_VBLANK_IRQ_EN
  assign irq_a = 1'b0;
  assign irq_b = 1'b0;
`endif

  // Memory: returns {y[3:0], x[7:0]} two clocks after the address.
  always @(posedge clk) begin
    m1_a  <= {py_a[3:0], px_a[7:0]};
    pix_a <= m1_a;
    m1_b  <= {py_b[3:0], px_b[7:0]};
    pix_b <= m1_b;
  end

  // Clock edges since the last reset edge.
  int t_a = 0, t_b = 0;
  bit armed_a = 1'b0, armed_b = 1'b0;
  always @(posedge clk) begin
    t_a     <= rst_a ? 0 : t_a + 1;
    t_b     <= rst_b ? 0 : t_b + 1;
    armed_a <= armed_a | rst_a;
    armed_b <= armed_b | rst_b;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected {x, y, rgb, hs, vs, irq} after t clock edges from reset.
  function automatic logic [34:0] model(input int t, input int div,
                                        input int ha, input int hf, input int hsy, input int hb,
                                        input int va, input int vf, input int vsy, input int vb);
    int ht, vt, p, pp, ph, pv;
    logic [31:0] bx, by, h, v;
    logic [11:0] rgb;
    logic hs, vs, irq;
    ht  = ha + hf + hsy + hb;
    vt  = va + vf + vsy + vb;
    p   = t / div;
    h   = 32'(p % ht);
    v   = 32'((p / ht) % vt);
    rgb = '0; hs = 1'b1; vs = 1'b1; irq = 1'b0;
    if (p > 0) begin
      pp = p - 1;
      ph = pp % ht;
      pv = (pp / ht) % vt;
      bx = 32'(ph);
      by = 32'(pv);
      if (ph < ha && pv < va) rgb = {by[3:0], bx[7:0]};
      if (ph >= ha + hf && ph < ha + hf + hsy) hs = 1'b0;
      if (pv >= va + vf && pv < va + vf + vsy) vs = 1'b0;
`ifdef VGA_VBLANK_IRQ_EN
      irq = (t % div == 0) && (ph == ht - 1) && (pv == va - 1);
`endif
    end
    return {h[9:0], v[9:0], rgb, hs, vs, irq};
  endfunction

  always @(negedge clk) begin
    if (armed_a)
      chk("cycle_a", 64'({px_a, py_a, r_a, g_a, b_a, hs_a, vs_a, irq_a}),
          64'(model(t_a, 4, 640, 16, 96, 48, 480, 10, 2, 33)));
    if (armed_b)
      chk("cycle_b", 64'({px_b, py_b, r_b, g_b, b_b, hs_b, vs_b, irq_b}),
          64'(model(t_b, 3, 16, 2, 4, 2, 8, 2, 2, 2)));
  end

  task automatic wait_a(input int x, input int y, input int limit, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(px_a == 10'(x) && py_a == 10'(y)) && n < limit);
    chk(nm, 64'({px_a, py_a}), 64'({10'(x), 10'(y)}));
  endtask

  task automatic wait_b(input int x, input int y, input int limit, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(px_b == 10'(x) && py_b == 10'(y)) && n < limit);
    chk(nm, 64'({px_b, py_b}), 64'({10'(x), 10'(y)}));
  endtask

  task automatic seq_a();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x", 64'(px_a), 64'd0);
    chk("rst_y", 64'(py_a), 64'd0);
    chk("rst_rgb", 64'({r_a, g_a, b_a}), 64'h000);
    chk("rst_hs", 64'(hs_a), 64'd1);
    chk("rst_vs", 64'(vs_a), 64'd1);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("tick_early", 64'(px_a), 64'd0);
    @(negedge clk);
    chk("first_tick", 64'(px_a), 64'd1);
    repeat (3) @(negedge clk);
    chk("x_hold", 64'(px_a), 64'd1);
    @(negedge clk);
    chk("x_step", 64'(px_a), 64'd2);
    wait_a(799, 0, 4000, "reach_799");
    repeat (3) @(negedge clk);
    chk("hold_799", 64'({px_a, py_a}), 64'({10'd799, 10'd0}));
    @(negedge clk);
    chk("line_wrap", 64'({px_a, py_a}), 64'({10'd0, 10'd1}));
    chk("line_len", 64'(t_a), 64'd3200);
    wait_a(6, 3, 8000, "reach_6_3");
    chk("rgb_5_3", 64'({r_a, g_a, b_a}), 64'h305);
    wait_a(641, 3, 4000, "reach_641");
    chk("rgb_blank", 64'({r_a, g_a, b_a}), 64'h000);
    wait_a(656, 3, 200, "reach_656");
    chk("hs_655", 64'(hs_a), 64'd1);
    wait_a(657, 3, 10, "reach_657");
    chk("hs_656", 64'(hs_a), 64'd0);
    wait_a(752, 3, 500, "reach_752");
    chk("hs_751", 64'(hs_a), 64'd0);
    wait_a(753, 3, 10, "reach_753");
    chk("hs_752", 64'(hs_a), 64'd1);
  endtask

  task automatic frame_b(input string tag);
    int n_irq = 0;
    for (int i = 1; i <= 1008; i++) begin
      @(negedge clk);
      if (irq_b) n_irq++;
`ifdef VGA_VBLANK_IRQ_EN
      if (i == 576) chk({tag, "_irq_at_0_8"}, 64'(irq_b), 64'd1);
`endif
      if (i == 1007) chk({tag, "_last_px"}, 64'({px_b, py_b}), 64'({10'd23, 10'd13}));
      if (i == 1008) chk({tag, "_wrap"}, 64'({px_b, py_b}), 64'd0);
    end
`ifdef VGA_VBLANK_IRQ_EN
    chk({tag, "_irq_count"}, 64'(n_irq), 64'd1);
`else
    chk({tag, "_irq_count"}, 64'(n_irq), 64'd0);
`endif
  endtask

  task automatic seq_b();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b_rst_hs", 64'(hs_b), 64'd1);
    rst_b = 1'b0;
    frame_b("b_f1");
    wait_b(19, 11, 2000, "b_reach_19_11");
    chk("b_pre_hs", 64'(hs_b), 64'd0);
    chk("b_pre_vs", 64'(vs_b), 64'd0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_mid_rst_xy", 64'({px_b, py_b}), 64'd0);
    chk("b_mid_rst_sync", 64'({hs_b, vs_b}), 64'b11);
    rst_b = 1'b0;
    frame_b("b_f2");
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
